// File: rtl/race_timer.sv
// Per-player race timer: counts ms ticks from start until each player finishes or saturates,
// then holds the results in DONE until the scoreboard requests a restart.
module race_timer #(
  parameter int unsigned CLK_DIV  = 65000,
  parameter logic [21:0] MAX_TIME = 22'd3999999
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        finish_p1_i,
  input  logic        finish_p2_i,
  input  logic        key_press_status_i,
  output logic [21:0] time_p1_o,
  output logic [21:0] time_p2_o,
  output logic        end_game_status_o,
  output logic        race_active_o
);

  localparam int unsigned PresW = $clog2(CLK_DIV);
  localparam logic [PresW-1:0] PresLast = PresW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRace = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PresW-1:0] pres_q, pres_d;
  logic [21:0]      time_p1_q, time_p1_d;
  logic [21:0]      time_p2_q, time_p2_d;
  logic             done_p1_q, done_p1_d;
  logic             done_p2_q, done_p2_d;
  logic             end_q, end_d;
  logic             active_q, active_d;
  logic             tick;
  logic             fin_p1, fin_p2;

  assign tick   = (state_q == StRace) && (pres_q == PresLast);
  // A player counts as finished in this cycle if already latched or finishing right now.
  assign fin_p1 = done_p1_q | finish_p1_i;
  assign fin_p2 = done_p2_q | finish_p2_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StRace;
      StRace:  if (fin_p1 && fin_p2) state_d = StDone;
      StDone:  if (key_press_status_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pres_d    = '0;
    time_p1_d = time_p1_q;
    time_p2_d = time_p2_q;
    done_p1_d = done_p1_q;
    done_p2_d = done_p2_q;
    end_d     = (state_d == StDone);
    active_d  = (state_d == StRace);
    case (state_q)
      StIdle: begin
        time_p1_d = '0;
        time_p2_d = '0;
        done_p1_d = 1'b0;
        done_p2_d = 1'b0;
      end
      StRace: begin
        pres_d = tick ? '0 : pres_q + PresW'(1);
        if (finish_p1_i) done_p1_d = 1'b1;
        if (finish_p2_i) done_p2_d = 1'b1;
        // A finish in the tick cycle suppresses that tick's increment.
        if (tick && !fin_p1) begin
          if (time_p1_q + 22'd1 >= MAX_TIME) begin
            time_p1_d = MAX_TIME;
            done_p1_d = 1'b1;
          end else begin
            time_p1_d = time_p1_q + 22'd1;
          end
        end
        if (tick && !fin_p2) begin
          if (time_p2_q + 22'd1 >= MAX_TIME) begin
            time_p2_d = MAX_TIME;
            done_p2_d = 1'b1;
          end else begin
            time_p2_d = time_p2_q + 22'd1;
          end
        end
      end
      StDone: begin
        if (state_d == StIdle) begin
          time_p1_d = '0;
          time_p2_d = '0;
          done_p1_d = 1'b0;
          done_p2_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pres_q    <= '0;
      time_p1_q <= '0;
      time_p2_q <= '0;
      done_p1_q <= 1'b0;
      done_p2_q <= 1'b0;
      end_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      pres_q    <= pres_d;
      time_p1_q <= time_p1_d;
      time_p2_q <= time_p2_d;
      done_p1_q <= done_p1_d;
      done_p2_q <= done_p2_d;
      end_q     <= end_d;
      active_q  <= active_d;
    end
  end

  assign time_p1_o         = time_p1_q;
  assign time_p2_o         = time_p2_q;
  assign end_game_status_o = end_q;
  assign race_active_o     = active_q;

endmodule

// File: tb/tb_race_timer.sv
// Bench for race_timer: per-race expected results are queued by the driver and checked by a
// monitor when end_game_status rises; directed checks cover idle, restart and reset behaviour.
module tb_race_timer;

  localparam int D    = 4;
  localparam int MAXT = 20;

  logic        clk = 1'b0;
  logic        reset, start, fin1, fin2, key;
  logic [21:0] t1, t2;
  logic        endg, act;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int base  = 0;

  typedef struct {
    int t1;
    int t2;
    int kd;
  } exp_t;
  exp_t sb_q[$];

  race_timer #(
    .CLK_DIV (D),
    .MAX_TIME(22'd20)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .start_i           (start),
    .finish_p1_i       (fin1),
    .finish_p2_i       (fin2),
    .key_press_status_i(key),
    .time_p1_o         (t1),
    .time_p2_o         (t2),
    .end_game_status_o (endg),
    .race_active_o     (act)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_t1"}, int'(t1), 0);
    chk({tag, "_t2"}, int'(t2), 0);
    chk({tag, "_end"}, int'(endg), 0);
    chk({tag, "_active"}, int'(act), 0);
  endtask

  // Monitor: compares a queued race result at every rising end_game_status.
  logic prev_end = 1'b0;
  logic prev_act = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    chk("t1_le_max", int'(t1 <= 22'(MAXT)), 1);
    chk("t2_le_max", int'(t2 <= 22'(MAXT)), 1);
    if (endg && !prev_end) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("race_t1", int'(t1), e.t1);
        chk("race_t2", int'(t2), e.t2);
        chk("done_cycle", cyc - base, e.kd);
        chk("active_fall", int'(act), 0);
        chk("active_before", int'(prev_act), 1);
      end
    end
    prev_end <= endg;
    prev_act <= act;
  end

  // Finish at race cycle c (cycle 0 = first RACE cycle). Ticks fall where (k+1)%D==0,
  // so a player finishing at c has seen c/D ticks; saturation makes done visible at MAXT*D.
  task automatic run_race(input int c1, input int c2, input int start_at, input bit lvl,
                          input int hold);
    exp_t e;
    int   e1, e2;
    e1   = (c1 < MAXT * D) ? c1 : MAXT * D;
    e2   = (c2 < MAXT * D) ? c2 : MAXT * D;
    e.t1 = (c1 / D < MAXT) ? c1 / D : MAXT;
    e.t2 = (c2 / D < MAXT) ? c2 / D : MAXT;
    e.kd = ((e1 > e2) ? e1 : e2) + 1;
    sb_q.push_back(e);
    start = 1'b1;
    step();
    start = 1'b0;
    base  = cyc;
    for (int k = 0; k <= e.kd + 1; k++) begin
      fin1  = lvl ? (k >= c1) : (k == c1);
      fin2  = lvl ? (k >= c2) : (k == c2);
      start = (k == start_at);
      step();
    end
    fin1  = 1'b0;
    fin2  = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("done_reached", int'(endg), 1);
    start = 1'b1;  // ignored in DONE
    step();
    start = 1'b0;
    repeat (hold) step();
    @(negedge clk);
    chk("hold_t1", int'(t1), e.t1);
    chk("hold_t2", int'(t2), e.t2);
    chk("hold_end", int'(endg), 1);
    chk("hold_active", int'(act), 0);
    key = 1'b1;
    step();
    check_idle("restart");
    step();
    key = 1'b0;
    step();
    check_idle("post_restart");
  endtask

  task automatic reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    base  = cyc;
    repeat (25) step();
    @(negedge clk);
    chk("pre_reset_t1", int'(t1), 6);
    chk("pre_reset_active", int'(act), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("mid_reset");
    for (int i = 0; i < 20; i++) begin
      fin1 = (i == 3) || (i == 9);
      fin2 = (i == 5);
      step();
    end
    fin1 = 1'b0;
    fin2 = 1'b0;
    check_idle("after_reset_finish");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fin1  = 1'b0;
    fin2  = 1'b0;
    key   = 1'b0;
    repeat (3) step();
    check_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      fin1 = (i == 10);
      key  = (i == 20);
      step();
      if (i % 10 == 9) check_idle("idle_hold");
    end
    fin1 = 1'b0;
    key  = 1'b0;

    run_race(40, 60, -1, 1'b0, 100);   // basic: 10 / 15
    run_race(31, 31, 13, 1'b0, 5);     // simultaneous on tick at 7, start mid-race
    run_race(20, 1000, -1, 1'b0, 5);   // player 2 saturates
    reset_mid();
    run_race(8, 12, -1, 1'b1, 3);      // fresh race after reset, held finish levels
    for (int r = 0; r < 8; r++) begin
      run_race(int'($urandom_range(0, 110)), int'($urandom_range(0, 110)),
               ($urandom % 2) ? int'($urandom_range(0, 30)) : -1,
               1'($urandom % 2), int'($urandom_range(1, 10)));
    end

    repeat (5) step();
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/race_timer.md
Name: race_timer

Overview:
- Measures each player's elapsed race time in milliseconds and raises the end-of-race flag.
- Sits directly upstream of the scoreboard stage and drives its time_p1, time_p2 and end_game_status inputs.
- Takes its restart request from the scoreboard's key_press_status output.
- Finish pulses come from the car/track logic. The start pulse comes from the countdown logic.

Parameters:
- CLK_DIV, 65000: clock cycles per time tick (1 ms at 65 MHz pixel clock); legal range ≥ 2.
- MAX_TIME, 22'd3999999: saturation value of each time counter; a player reaching it is forced finished.

Ports:
- clk  input  1  system clock (pixel clock domain).
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; race begins.
- finish_p1  input  1  pulse/level; player 1 crossed finish line.
- finish_p2  input  1  pulse/level; player 2 crossed finish line.
- key_press_status  input  1  restart request from the scoreboard; honoured only in DONE.
- time_p1  output  22  player 1 elapsed ticks.
- time_p2  output  22  player 2 elapsed ticks.
- end_game_status  output  1  high while in DONE.
- race_active  output  1  high while in RACE.

Behaviour:
- One clock domain; every output is registered. There are no combinational paths from input to output.
- Reset: state=IDLE, time_p1=time_p2=0, end_game_status=0, race_active=0, prescaler=0, done_p1=done_p2=0. Reset mid-race has the same effect, taking effect on the next edge.
- States: IDLE, RACE, DONE; 2-bit state register.
- IDLE:
  - Times are held at 0 and done flags cleared.
  - start=1 moves to RACE on the next edge, with prescaler=0 and race_active=1.
  - key_press_status and finish_px are ignored.
- RACE, prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick=1 in the cycle the prescaler equals CLK_DIV-1.
  - The first tick occurs CLK_DIV cycles after entry.
- RACE, finish latching:
  - finish_px=1 sets done_px, which is sticky until IDLE.
  - Repeat or held finish levels have no further effect.
- RACE, time counters:
  - On tick, time_px increments by 1 only if done_px=0 and finish_px=0 in that cycle.
  - A finish coinciding with a tick suppresses that increment.
- RACE, saturation:
  - If time_px would become MAX_TIME, it is written as MAX_TIME and done_px is set in the same edge.
  - time_px never exceeds MAX_TIME and never wraps.
- RACE, exit to DONE:
  - When (done_p1 or finish_p1) and (done_p2 or finish_p2) hold in a cycle, or saturation completes the last player, the next edge enters DONE.
  - That edge sets end_game_status=1 and race_active=0.
  - Simultaneous finishes in the same cycle give equal times and a single DONE transition.
- start during RACE or DONE is ignored.
- DONE:
  - time_p1 and time_p2 are frozen.
  - key_press_status=1 moves to IDLE on the next edge; times are cleared to 0 and end_game_status drops to 0 on that edge.
- Restart semantics:
  - The scoreboard clears key_press_status one cycle after end_game_status falls.
  - The residual high cycle in IDLE is harmless because IDLE ignores key_press_status.
  - A new race requires a fresh start pulse.
- Width rule: the prescaler is sized as $clog2(CLK_DIV) bits. Time arithmetic is unsigned 22-bit.
- Ties (time_p1==time_p2) are legal output. Winner resolution belongs to the scoreboard.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset 3 cycles, release, hold for 50 cycles with no start; pulse finish_p1 and key_press_status during the hold.
  - Required: times stay 0; end_game_status=0; race_active=0.
- Basic race (CLK_DIV=4):
  - Stimulus: start at cycle 0; finish_p1 after 10 ticks; finish_p2 after 15 ticks.
  - Required: time_p1=10, time_p2=15.
  - Required: end_game_status rises exactly one cycle after the finish_p2 sample; race_active falls on the same edge.
- Simultaneous events (CLK_DIV=4):
  - Stimulus: finish_p1 and finish_p2 together on a tick cycle with both at 7.
  - Required: both frozen at 7, not 8; DONE entered once.
  - Stimulus: start asserted during RACE.
  - Required: no counter reset.
- Saturation (MAX_TIME=20, CLK_DIV=4):
  - Stimulus: finish_p1 at 5 ticks; player 2 never finishes.
  - Required: time_p2 stops at 20; DONE entered on the saturating edge +1 cycle; time_p2 never reads 21 or 0.
- Restart handshake:
  - Stimulus: in DONE, hold for 100 cycles, then pulse key_press_status.
  - Required: times hold through the 100 cycles.
  - Required: next edge gives IDLE, times 0, end_game_status=0.
  - Stimulus: new start; required: a fresh race counts from 0.
- Reset mid-race:
  - Stimulus: assert reset with time_p1=6.
  - Required: next edge gives all outputs 0, state IDLE; finish pulses before the next start are ignored.
